// File: rtl/time_pkg.sv
// Shared types and constants for the time-of-day controller: state encoding,
// field widths, rollover limits and a small wrapping-increment helper.
package time_pkg;

  localparam int HOURS_W   = 5;
  localparam int MINUTES_W = 6;
  localparam int SECONDS_W = 6;
  localparam int MODE_W    = 2;

  localparam logic [SECONDS_W-1:0] SECONDS_MAX = 6'd59;
  localparam logic [MINUTES_W-1:0] MINUTES_MAX = 6'd59;

  // 2'b11 is deliberately left unnamed; the FSM treats it as corrupt state.
  typedef enum logic [MODE_W-1:0] {
    RUN         = 2'b00,
    SET_HOURS   = 2'b01,
    SET_MINUTES = 2'b10
  } mode_e;

  function automatic logic [5:0] wrap_inc6(input logic [5:0] value,
                                           input logic [5:0] max_value);
    return (value == max_value) ? 6'd0 : value + 6'd1;
  endfunction

endpackage

// File: rtl/time_controller_if.sv
// Display-side bundle of the time controller: the clock fields, the current
// mode and the blink enable for the field being edited.
interface time_controller_if;
  import time_pkg::*;

  logic [HOURS_W-1:0]   hours;
  logic [MINUTES_W-1:0] minutes;
  logic [SECONDS_W-1:0] seconds;
  logic [MODE_W-1:0]    mode;
  logic                 blink;

  modport master (
    output hours,
    output minutes,
    output seconds,
    output mode,
    output blink
  );

  modport slave (
    input hours,
    input minutes,
    input seconds,
    input mode,
    input blink
  );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; emits a single
// clk-cycle pulse per low-to-high transition of an asynchronous input.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  // Combinational so the consumer acts on the 3rd edge that sees the input high.
  assign pulse = sync_reg & ~prev_reg;

endmodule

// File: rtl/time_controller.sv
// Time-of-day counter with RUN / SET_HOURS / SET_MINUTES modes driven by a
// divided tick and two debounced buttons, all synchronized internally.
module time_controller
  import time_pkg::*;
#(
  parameter int ticks_per_second = 2,
  parameter int hour_limit       = 24
) (
  input  logic                  input_clock,
  input  logic                  reset_n,
  input  logic                  tick_in,
  input  logic                  mode_btn,
  input  logic                  inc_btn,
  time_controller_if.master     disp
);

  localparam int SUB_W = (ticks_per_second > 1) ? $clog2(ticks_per_second) : 1;
  localparam logic [SUB_W-1:0]   SUB_MAX  = SUB_W'(ticks_per_second - 1);
  localparam logic [HOURS_W-1:0] HOUR_MAX = HOURS_W'(hour_limit - 1);

  logic [2:0] raw_in;
  logic [2:0] pulse;
  logic       tick_p;
  logic       mode_p;
  logic       inc_p;

  assign raw_in = {inc_btn, mode_btn, tick_in};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      sync_edge u_sync (
        .clk      (input_clock),
        .rst_n    (reset_n),
        .async_in (raw_in[gi]),
        .pulse    (pulse[gi])
      );
    end
  endgenerate

  assign tick_p = pulse[0];
  assign mode_p = pulse[1];
  assign inc_p  = pulse[2];

  mode_e                state_reg,   state_next;
  logic [HOURS_W-1:0]   hours_reg,   hours_next;
  logic [MINUTES_W-1:0] minutes_reg, minutes_next;
  logic [SECONDS_W-1:0] seconds_reg, seconds_next;
  logic [SUB_W-1:0]     sub_reg,     sub_next;
  logic                 blink_reg,   blink_next;

  logic [HOURS_W-1:0]   hours_inc;
  logic [MINUTES_W-1:0] minutes_inc;
  logic [SECONDS_W-1:0] seconds_inc;
  logic                 sub_wrap;

  assign hours_inc   = (hours_reg == HOUR_MAX) ? '0 : hours_reg + HOURS_W'(1);
  assign minutes_inc = wrap_inc6(minutes_reg, MINUTES_MAX);
  assign seconds_inc = wrap_inc6(seconds_reg, SECONDS_MAX);
  assign sub_wrap    = (sub_reg == SUB_MAX);

  always_ff @(posedge input_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= RUN;
      hours_reg   <= '0;
      minutes_reg <= '0;
      seconds_reg <= '0;
      sub_reg     <= '0;
      blink_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hours_reg   <= hours_next;
      minutes_reg <= minutes_next;
      seconds_reg <= seconds_next;
      sub_reg     <= sub_next;
      blink_reg   <= blink_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hours_next   = hours_reg;
    minutes_next = minutes_reg;
    seconds_next = seconds_reg;
    sub_next     = sub_reg;
    blink_next   = blink_reg;

    case (state_reg)
      RUN: begin
        blink_next = 1'b0;
        // A tick landing with the mode press is still counted before leaving RUN.
        if (tick_p) begin
          sub_next = sub_wrap ? '0 : sub_reg + SUB_W'(1);
          if (sub_wrap) begin
            seconds_next = seconds_inc;
            if (seconds_reg == SECONDS_MAX) begin
              minutes_next = minutes_inc;
              if (minutes_reg == MINUTES_MAX) begin
                hours_next = hours_inc;
              end
            end
          end
        end
        if (mode_p) begin
          state_next = SET_HOURS;
          blink_next = 1'b1;
        end
      end

      SET_HOURS: begin
        if (mode_p) begin
          state_next = SET_MINUTES;
          blink_next = 1'b1;
        end else begin
          if (inc_p) begin
            hours_next = hours_inc;
          end
          if (tick_p) begin
            blink_next = ~blink_reg;
          end
        end
      end

      SET_MINUTES: begin
        if (mode_p) begin
          state_next   = RUN;
          seconds_next = '0;
          sub_next     = '0;
          blink_next   = 1'b0;
        end else begin
          if (inc_p) begin
            minutes_next = minutes_inc;
          end
          if (tick_p) begin
            blink_next = ~blink_reg;
          end
        end
      end

      default: begin
        state_next = RUN;
        blink_next = 1'b0;
      end
    endcase
  end

  assign disp.hours   = hours_reg;
  assign disp.minutes = minutes_reg;
  assign disp.seconds = seconds_reg;
  assign disp.mode    = state_reg;
  assign disp.blink   = blink_reg;

endmodule

// File: tb/tb_time_controller.sv
// Self-checking bench for time_controller: a literal vector table, directed
// multi-cycle sequences and random events against a total-seconds model.
module tb_time_controller;

  localparam int TPS   = 2;
  localparam int HLIM  = 24;
  localparam int DAY_S = HLIM * 3600;

  localparam logic [2:0] EV_T  = 3'b001;
  localparam logic [2:0] EV_M  = 3'b010;
  localparam logic [2:0] EV_I  = 3'b100;
  localparam logic [2:0] EV_MI = 3'b110;
  localparam logic [2:0] EV_MT = 3'b011;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick_in = 1'b0;
  logic mode_btn = 1'b0;
  logic inc_btn = 1'b0;

  time_controller_if disp();

  time_controller #(.ticks_per_second(TPS), .hour_limit(HLIM)) dut (
    .input_clock (clk),
    .reset_n     (reset_n),
    .tick_in     (tick_in),
    .mode_btn    (mode_btn),
    .inc_btn     (inc_btn),
    .disp        (disp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: absolute seconds of the day plus sub-second phase.
  int m_t;
  int m_sub;
  int m_mode;
  bit m_blink;

  typedef struct {
    logic [2:0] ev;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] md;
    logic       bl;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [19:0] pack(input int h, input int m, input int s,
                                       input int md, input bit bl);
    return {5'(h), 6'(m), 6'(s), 2'(md), bl};
  endfunction

  function automatic logic [19:0] model_exp();
    return pack(m_t / 3600, (m_t / 60) % 60, m_t % 60, m_mode, m_blink);
  endfunction

  task automatic model_reset();
    m_t = 0; m_sub = 0; m_mode = 0; m_blink = 1'b0;
  endtask

  task automatic model_event(input logic [2:0] ev);
    int h;
    int mi;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    if (m_mode == 0) begin
      if (ev[0]) begin
        m_sub++;
        if (m_sub == TPS) begin
          m_sub = 0;
          m_t = (m_t + 1) % DAY_S;
        end
      end
      if (ev[1]) begin
        m_mode = 1; m_blink = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (ev[1]) begin
        m_mode = 2; m_blink = 1'b1;
      end else begin
        if (ev[2]) m_t = m_t - h * 3600 + ((h + 1) % HLIM) * 3600;
        if (ev[0]) m_blink = !m_blink;
      end
    end else begin
      if (ev[1]) begin
        m_t = m_t - (m_t % 60); m_sub = 0; m_mode = 0; m_blink = 1'b0;
      end else begin
        if (ev[2]) m_t = m_t - mi * 60 + ((mi + 1) % 60) * 60;
        if (ev[0]) m_blink = !m_blink;
      end
    end
  endtask

  task automatic check(input string name, input logic [19:0] exp_v);
    logic [19:0] act;
    act = {disp.hours, disp.minutes, disp.seconds, disp.mode, disp.blink};
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d:%0d:%0d mode=%0d blink=%0d, expected %0d:%0d:%0d mode=%0d blink=%0d",
               name, act[19:15], act[14:9], act[8:3], act[2:1], act[0],
               exp_v[19:15], exp_v[14:9], exp_v[8:3], exp_v[2:1], exp_v[0]);
    end
  endtask

  task automatic apply(input logic [2:0] ev);
    @(negedge clk);
    tick_in = ev[0]; mode_btn = ev[1]; inc_btn = ev[2];
    repeat (4) @(negedge clk);
    tick_in = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    repeat (3) @(negedge clk);
    model_event(ev);
  endtask

  task automatic apply_n(input logic [2:0] ev, input int n);
    for (int k = 0; k < n; k++) apply(ev);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    tick_in = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
  endtask

  initial begin
    tbl[0]  = '{EV_M,  5'd0, 6'd0, 6'd0, 2'd1, 1'b1};
    tbl[1]  = '{EV_I,  5'd1, 6'd0, 6'd0, 2'd1, 1'b1};
    tbl[2]  = '{EV_T,  5'd1, 6'd0, 6'd0, 2'd1, 1'b0};
    tbl[3]  = '{EV_T,  5'd1, 6'd0, 6'd0, 2'd1, 1'b1};
    tbl[4]  = '{EV_M,  5'd1, 6'd0, 6'd0, 2'd2, 1'b1};
    tbl[5]  = '{EV_I,  5'd1, 6'd1, 6'd0, 2'd2, 1'b1};
    tbl[6]  = '{EV_MI, 5'd1, 6'd1, 6'd0, 2'd0, 1'b0};
    tbl[7]  = '{EV_T,  5'd1, 6'd1, 6'd0, 2'd0, 1'b0};
    tbl[8]  = '{EV_T,  5'd1, 6'd1, 6'd1, 2'd0, 1'b0};
    tbl[9]  = '{EV_T,  5'd1, 6'd1, 6'd1, 2'd0, 1'b0};
    tbl[10] = '{EV_MT, 5'd1, 6'd1, 6'd2, 2'd1, 1'b1};
    tbl[11] = '{EV_T,  5'd1, 6'd1, 6'd2, 2'd1, 1'b0};
    tbl[12] = '{EV_M,  5'd1, 6'd1, 6'd2, 2'd2, 1'b1};
    tbl[13] = '{EV_M,  5'd1, 6'd1, 6'd0, 2'd0, 1'b0};

    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", pack(0, 0, 0, 0, 0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Literal vector table, including mode+inc and mode+tick collisions.
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].ev);
      check($sformatf("tbl[%0d]", i),
            {tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].md, tbl[i].bl});
      $display("vec %0d ev=%b -> %0d:%0d:%0d mode=%0d blink=%0d", i, tbl[i].ev,
               disp.hours, disp.minutes, disp.seconds, disp.mode, disp.blink);
    end

    // 120 ticks from reset make one minute.
    do_reset();
    apply_n(EV_T, 120);
    check("one_minute", pack(0, 1, 0, 0, 0));

    // Set 23:59, run to 23:59:59, then roll over the day.
    do_reset();
    apply(EV_M); apply_n(EV_I, 23); apply(EV_M); apply_n(EV_I, 59); apply(EV_M);
    check("set_2359", pack(23, 59, 0, 0, 0));
    apply_n(EV_T, 118);
    check("at_235959", pack(23, 59, 59, 0, 0));
    apply_n(EV_T, 2);
    check("day_rollover", pack(0, 0, 0, 0, 0));

    // Hour wrap in SET_HOURS leaves seconds alone.
    do_reset();
    apply_n(EV_T, 6);
    apply(EV_M);
    apply_n(EV_I, 24);
    check("hours_wrap", pack(0, 0, 3, 1, 1));
    apply(EV_I);
    check("hours_after_wrap", pack(1, 0, 3, 1, 1));

    // Leaving SET_MINUTES clears seconds; long tick high yields one pulse.
    do_reset();
    apply_n(EV_T, 74);
    apply(EV_M); apply(EV_M);
    check("at_0037_setmin", pack(0, 0, 37, 2, 1));
    apply(EV_M);
    check("exit_clears_sec", pack(0, 0, 0, 0, 0));
    @(negedge clk);
    tick_in = 1'b1;
    repeat (50) @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    model_event(EV_T);
    check("held_tick_once", model_exp());
    apply(EV_T);
    check("held_tick_then_one", pack(0, 0, 1, 0, 0));

    // A tick edge caught mid-synchronizer is dropped by reset.
    do_reset();
    @(negedge clk);
    tick_in = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    tick_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("pending_discard", pack(0, 0, 0, 0, 0));
    apply(EV_T);
    check("after_discard_tick", pack(0, 0, 0, 0, 0));

    // Async reset from 05:10:20 in SET_MINUTES clears outputs before next edge.
    do_reset();
    apply(EV_M); apply_n(EV_I, 5); apply(EV_M); apply_n(EV_I, 10); apply(EV_M);
    apply_n(EV_T, 40);
    apply(EV_M); apply(EV_M);
    check("at_051020_setmin", pack(5, 10, 20, 2, 1));
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", pack(0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();

    // Random event stream against the model.
    for (int i = 0; i < 250; i++) begin
      int r;
      logic [2:0] ev;
      r = int'($urandom_range(0, 9));
      if (r < 5)       ev = EV_T;
      else if (r < 7)  ev = EV_M;
      else if (r < 9)  ev = EV_I;
      else             ev = ($urandom_range(0, 1) == 0) ? EV_MI : EV_MT;
      apply(ev);
      check($sformatf("rand[%0d] ev=%b", i, ev), model_exp());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
